mem_port_arbiter2: RTL and testbench
====================================

Name: mem_port_arbiter2

Overview:
- Shares one memory port between two requesters: A, the instruction-fetch side, and B, the load/store side.
- Serialises their transactions and generates the select for the downstream 2:1 address/data muxes.
- Holds a grant for the whole transaction, alternates priority on ties, and aborts stalled transfers with a watchdog.
- Sits between the core's fetch/memory stages and the single-ported memory interface.

Parameters:
- WIDTH, 32: address and data width in bits.
- TIMEOUT, 16: cycles allowed from grant to mem_ready before abort. Must be ≥ 2.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- req_a, input, 1: requester A transaction request. Held until done_a.
- addr_a, input, WIDTH: A address.
- wdata_a, input, WIDTH: A write data.
- we_a, input, 1: A write enable.
- req_b, input, 1: requester B request.
- addr_b, input, WIDTH: B address.
- wdata_b, input, WIDTH: B write data.
- we_b, input, 1: B write enable.
- mem_ready, input, 1: memory completes the current transfer this cycle.
- mem_rdata, input, WIDTH: memory read data, valid with mem_ready.
- mem_req, output, 1: transfer active toward memory.
- mem_addr, output, WIDTH: latched address of the granted requester.
- mem_wdata, output, WIDTH: latched write data.
- mem_we, output, 1: latched write enable.
- sel, output, 1: 0 = A owns the port, 1 = B owns the port. Drives the downstream mux select.
- gnt_a, output, 1: A currently owns the port.
- gnt_b, output, 1: B currently owns the port.
- done_a, output, 1: one-cycle pulse, A transaction finished.
- done_b, output, 1: one-cycle pulse, B transaction finished.
- rdata, output, WIDTH: registered read data, valid with done_a/done_b.
- err, output, 1: one-cycle pulse alongside done_x when the watchdog aborted the transfer.

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; watchdog counter 0; last_served=B, so A wins the first tie. Reset mid-transfer drops mem_req immediately; no done is produced for the aborted transfer.
- FSM states: IDLE, GRANT_A, GRANT_B. All outputs except sel are registered or decoded from state and registers only. No combinational path from req to mem_*.
- IDLE arbitration, evaluated every cycle:
  - Masking: a requester whose done_x is high this cycle is masked and treated as not requesting.
  - Only A requesting -> GRANT_A.
  - Only B requesting -> GRANT_B.
  - Both requesting -> grant the one that is not last_served.
  - Neither -> stay in IDLE.
- On the arbitration edge: capture the winner's addr/wdata/we into the mem_* registers and load watchdog=0.
- GRANT_x:
  - mem_req=1, gnt_x=1; sel=0 for A, 1 for B.
  - The latched address/data stay stable regardless of input changes.
  - Watchdog increments each cycle.
- Completion: mem_ready=1 in GRANT_x -> next edge: rdata<=mem_rdata (also on writes), done_x=1 for one cycle, last_served=x, state=IDLE.
- Watchdog: counter reaches TIMEOUT-1 without mem_ready -> next edge: done_x=1, err=1, rdata=0, last_served=x, state=IDLE.
  - If mem_ready and the timeout occur in the same cycle, mem_ready wins: normal completion, err=0.
- Latency:
  - req in IDLE at cycle 0 -> mem_req at cycle 1.
  - mem_ready at cycle k≥1 -> done at k+1.
  - Earliest next grant is cycle k+2, so there is at least one IDLE cycle between transfers.
- Requester dropping req while granted: the transfer still completes and done still pulses. There is no cancel.
- mem_ready while in IDLE is ignored.
- Fairness: under continuous requests from both sides, grants strictly alternate A, B, A, ...
- sel holds its last value in IDLE. Reset value is 0.

Test Plan:
- Single read: req_a, addr_a=0x100, mem_ready at cycle 3 with rdata 0xDEADBEEF. Required: mem_req cycles 1–3, mem_addr=0x100, sel=0, done_a=1 and rdata=0xDEADBEEF at cycle 4, err=0.
- Tie: req_a and req_b both asserted at cycle 0 after reset, mem_ready one cycle after each grant. Required: A granted first, then B (sel=1, mem_addr=addr_b), then A again. Grant order A,B,A; each done pulses exactly once.
- Done masking: A holds req_a high through its done_a cycle, B idle. Required: no second grant to A in the done_a cycle; the next A grant starts two cycles after done_a.
- Watchdog: TIMEOUT=16, B write, mem_ready never asserted. Required: mem_req high for exactly 16 cycles, then done_b=1, err=1, rdata=0. A pending request is granted next.
- Reset mid-transfer: assert reset in cycle 2 of GRANT_A. Required: mem_req, gnt_a and sel go to 0 immediately; no done_a; after release with both requesting, A wins.
- Input stability: change addr_a and we_a while in GRANT_A. Required: mem_addr and mem_we keep the values captured at grant.

Source files
------------

// File: rtl/mem_port_arbiter2.sv
// Two-requester arbiter for a single memory port: instruction fetch (A) vs load/store (B).
// Holds the grant for a whole transfer, alternates on ties and aborts stalled transfers.
module mem_port_arbiter2 #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] addr_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic             we_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] addr_b,
  input  logic [WIDTH-1:0] wdata_b,
  input  logic             we_b,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             sel,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic [WIDTH-1:0] rdata,
  output logic             err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wd_q, wd_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             we_q, we_d;
  logic             sel_q, sel_d;
  logic             last_b_q, last_b_d;
  logic             done_a_q, done_a_d;
  logic             done_b_q, done_b_d;
  logic             err_q, err_d;
  logic             req_a_m, req_b_m, timeout;

  // A requester still seeing its own done pulse has not had a chance to drop req yet.
  assign req_a_m = req_a & ~done_a_q;
  assign req_b_m = req_b & ~done_b_q;
  assign timeout = (wd_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    last_b_d = last_b_q;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_a_m && (!req_b_m || last_b_q)) begin
          state_d = GRANT_A;
          addr_d  = addr_a;
          wdata_d = wdata_a;
          we_d    = we_a;
          sel_d   = 1'b0;
          wd_d    = '0;
        end else if (req_b_m) begin
          state_d = GRANT_B;
          addr_d  = addr_b;
          wdata_d = wdata_b;
          we_d    = we_b;
          sel_d   = 1'b1;
          wd_d    = '0;
        end
      end
      GRANT_A, GRANT_B: begin
        // A late mem_ready on the final watchdog cycle still counts as a normal completion.
        if (mem_ready || timeout) begin
          state_d  = IDLE;
          rdata_d  = mem_ready ? mem_rdata : '0;
          err_d    = ~mem_ready;
          last_b_d = (state_q == GRANT_B);
          done_a_d = (state_q == GRANT_A);
          done_b_d = (state_q == GRANT_B);
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wd_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= 1'b0;
      rdata_q  <= '0;
      last_b_q <= 1'b1;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      last_b_q <= last_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      err_q    <= err_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign gnt_a     = (state_q == GRANT_A);
  assign gnt_b     = (state_q == GRANT_B);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign sel       = sel_q;
  assign done_a    = done_a_q;
  assign done_b    = done_b_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter2.sv
// Directed bench for mem_port_arbiter2: stimulus pushes expected grants/completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, we_a, req_b, we_b, mem_ready;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b, mem_rdata;
  logic        mem_req, mem_we, sel, gnt_a, gnt_b, done_a, done_b, err;
  logic [31:0] mem_addr, mem_wdata, rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        side;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grantExp_t;

  typedef struct {
    logic        side;
    logic        err;
    logic [31:0] rdata;
  } doneExp_t;

  grantExp_t grantQ[$];
  doneExp_t  doneQ[$];
  logic      memReqPrev = 1'b0;

  mem_port_arbiter2 #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .we_a      (we_a),
    .req_b     (req_b),
    .addr_b    (addr_b),
    .wdata_b   (wdata_b),
    .we_b      (we_b),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .sel       (sel),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .done_a    (done_a),
    .done_b    (done_b),
    .rdata     (rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic side, input logic req, input logic [31:0] addr,
                               input logic we, input logic [31:0] wdata);
    if (side == 1'b0) begin
      req_a = req; addr_a = addr; we_a = we; wdata_a = wdata;
    end else begin
      req_b = req; addr_b = addr; we_b = we; wdata_b = wdata;
    end
  endtask

  task automatic expectGrant(input logic side, input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    grantExp_t g;
    g.side = side; g.addr = addr; g.we = we; g.wdata = wdata;
    grantQ.push_back(g);
  endtask

  task automatic expectDone(input logic side, input logic e, input logic [31:0] d);
    doneExp_t x;
    x.side = side; x.err = e; x.rdata = d;
    doneQ.push_back(x);
  endtask

  // One-cycle mem_ready in the current cycle, returning in the following cycle.
  task automatic readyPulse(input logic [31:0] d);
    mem_ready = 1'b1;
    mem_rdata = d;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  always @(negedge clk) begin
    if (mem_req && !memReqPrev) begin
      if (grantQ.size() == 0) begin
        checkOutput("unexpected_grant", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        grantExp_t g;
        g = grantQ.pop_front();
        checkOutput("grant_sel", 32'(sel), 32'(g.side));
        checkOutput("grant_gnt_b", 32'(gnt_b), 32'(g.side));
        checkOutput("grant_addr", mem_addr, g.addr);
        checkOutput("grant_we", 32'(mem_we), 32'(g.we));
        checkOutput("grant_wdata", mem_wdata, g.wdata);
      end
    end
    memReqPrev = mem_req;
    if (done_a || done_b) begin
      if (doneQ.size() == 0) begin
        checkOutput("unexpected_done", {30'h0, done_b, done_a}, 32'h0);
      end else begin
        doneExp_t x;
        x = doneQ.pop_front();
        checkOutput("done_side_b", 32'(done_b), 32'(x.side));
        checkOutput("done_side_a", 32'(done_a), 32'(!x.side));
        checkOutput("done_err", 32'(err), 32'(x.err));
        checkOutput("done_rdata", rdata, x.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int cnt;
    reset = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = 32'h0; wdata_a = 32'h0;
    req_b = 1'b0; we_b = 1'b0; addr_b = 32'h0; wdata_b = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) tick();
    reset = 1'b0;

    checkOutput("reset_mem_req", 32'(mem_req), 32'h0);
    checkOutput("reset_gnt_a", 32'(gnt_a), 32'h0);
    checkOutput("reset_gnt_b", 32'(gnt_b), 32'h0);
    checkOutput("reset_sel", 32'(sel), 32'h0);
    checkOutput("reset_done", {30'h0, done_b, done_a}, 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);

    // Single read: request in cycle 0, mem_ready in cycle 3, done in cycle 4
    expectGrant(1'b0, 32'h100, 1'b0, 32'h0);
    expectDone(1'b0, 1'b0, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    checkOutput("read_mem_req_c1", 32'(mem_req), 32'h1);
    checkOutput("read_mem_addr", mem_addr, 32'h100);
    checkOutput("read_sel", 32'(sel), 32'h0);
    tick();
    checkOutput("read_mem_req_c2", 32'(mem_req), 32'h1);
    tick();
    checkOutput("read_mem_req_c3", 32'(mem_req), 32'h1);
    readyPulse(32'hDEADBEEF);
    checkOutput("read_done_c4", 32'(done_a), 32'h1);
    checkOutput("read_rdata_c4", rdata, 32'hDEADBEEF);
    checkOutput("read_mem_req_c4", 32'(mem_req), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("read_done_one_cycle", 32'(done_a), 32'h0);
    tick();

    // Tie after reset: A, B, A
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expectGrant(1'b0, 32'h200, 1'b0, 32'h0);
    expectGrant(1'b1, 32'h300, 1'b1, 32'h55);
    expectGrant(1'b0, 32'h204, 1'b0, 32'h0);
    expectDone(1'b0, 1'b0, 32'h11);
    expectDone(1'b1, 1'b0, 32'h22);
    expectDone(1'b0, 1'b0, 32'h33);
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 32'h55);
    tick();
    checkOutput("tie_first_gnt_a", 32'(gnt_a), 32'h1);
    readyPulse(32'h11);
    checkOutput("tie_done_a", 32'(done_a), 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h204, 1'b0, 32'h0);
    tick();
    checkOutput("tie_second_gnt_b", 32'(gnt_b), 32'h1);
    checkOutput("tie_second_sel", 32'(sel), 32'h1);
    readyPulse(32'h22);
    checkOutput("tie_done_b", 32'(done_b), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("tie_third_gnt_a", 32'(gnt_a), 32'h1);
    readyPulse(32'h33);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) tick();

    // Latched request fields ignore input changes during the grant
    expectGrant(1'b0, 32'hA00, 1'b1, 32'h1234);
    expectDone(1'b0, 1'b0, 32'h77);
    applyStimulus(1'b0, 1'b1, 32'hA00, 1'b1, 32'h1234);
    tick();
    applyStimulus(1'b0, 1'b1, 32'hBBB, 1'b0, 32'h0);
    tick();
    checkOutput("stable_mem_addr", mem_addr, 32'hA00);
    checkOutput("stable_mem_we", 32'(mem_we), 32'h1);
    checkOutput("stable_mem_wdata", mem_wdata, 32'h1234);
    readyPulse(32'h77);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) tick();

    // Done masking: A holds req through done_a; re-grant two cycles later
    expectGrant(1'b0, 32'h400, 1'b0, 32'h0);
    expectGrant(1'b0, 32'h404, 1'b0, 32'h0);
    expectDone(1'b0, 1'b0, 32'h44);
    expectDone(1'b0, 1'b0, 32'h45);
    applyStimulus(1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    tick();
    readyPulse(32'h44);
    checkOutput("mask_done_a", 32'(done_a), 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h404, 1'b0, 32'h0);
    tick();
    checkOutput("mask_no_regrant", 32'(mem_req), 32'h0);
    tick();
    checkOutput("mask_regrant_gnt_a", 32'(gnt_a), 32'h1);
    readyPulse(32'h45);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) tick();

    // Watchdog: B write never acknowledged, A waiting behind it
    expectGrant(1'b1, 32'h500, 1'b1, 32'hCAFE);
    expectDone(1'b1, 1'b1, 32'h0);
    expectGrant(1'b0, 32'h600, 1'b0, 32'h0);
    expectDone(1'b0, 1'b0, 32'h66);
    applyStimulus(1'b1, 1'b1, 32'h500, 1'b1, 32'hCAFE);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    checkOutput("wd_req_cycles", 32'(cnt), 32'd16);
    checkOutput("wd_done_b", 32'(done_b), 32'h1);
    checkOutput("wd_err", 32'(err), 32'h1);
    checkOutput("wd_rdata_zero", rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("wd_next_gnt_a", 32'(gnt_a), 32'h1);
    readyPulse(32'h66);
    checkOutput("wd_after_err_clear", 32'(err), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) tick();

    // Reset in the second GRANT_A cycle: no done, A wins the tie afterwards
    expectGrant(1'b0, 32'h700, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_mid_gnt_a", 32'(gnt_a), 32'h0);
    checkOutput("rst_mid_sel", 32'(sel), 32'h0);
    checkOutput("rst_mid_done_a", 32'(done_a), 32'h0);
    tick();
    expectGrant(1'b0, 32'h800, 1'b0, 32'h0);
    expectGrant(1'b1, 32'h900, 1'b0, 32'h0);
    expectDone(1'b0, 1'b0, 32'h88);
    expectDone(1'b1, 1'b0, 32'h99);
    applyStimulus(1'b0, 1'b1, 32'h800, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h900, 1'b0, 32'h0);
    reset = 1'b0;
    tick();
    checkOutput("rst_after_a_wins", 32'(gnt_a), 32'h1);
    readyPulse(32'h88);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("rst_after_then_b", 32'(gnt_b), 32'h1);
    readyPulse(32'h99);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) tick();

    checkOutput("grant_queue_empty", 32'(grantQ.size()), 32'h0);
    checkOutput("done_queue_empty", 32'(doneQ.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
